hazard_ctrl_unit: RTL

Pipeline hazard and stall controller for the 5-stage MIPS datapath in `Top_Level`. It detects load-use hazards between the ID and EX stages and sequences the multi-cycle multiply/divide unit (MDU). It redirects the front end on taken branches and jumps resolved in EX. It drives the PC, IF/ID and ID/EX pipeline-register controls.

---
 rtl/hazard_ctrl_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use / MDU stall and branch-redirect controller for the 5-stage MIPS pipeline.
// Optional feature macro: HAZARD_MDU_EN builds the multi-cycle MDU sequencer (FSM + down-counter).
// Ports:
//   Clk, Rst                   clock (rising edge), asynchronous active-high reset
//   ID_Rs, ID_Rt               source registers of the ID instruction
//   ID_UsesRs, ID_UsesRt       ID instruction actually reads Rs / Rt
//   ID_IsMdu, ID_ReadsHiLo     ID instruction is MULT/DIV family / MFHI/MFLO
//   EX_MemRead, EX_Rd          EX instruction is a load, and its destination
//   EX_BranchTaken, EX_Jump    control transfer resolved in EX
//   PCWrite, IFIDWrite         front-end register enables
//   IFIDFlush, IDEXBubble      squash IF/ID, insert NOP into ID/EX
//   MduStart                   launch the MDU this cycle
//   MduBusy                    registered, MDU running
//   StallCount                 registered, saturating stall-cycle counter
module hazard_ctrl_unit #(
    parameter int MDU_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_IsMdu,
    input  logic        ID_ReadsHiLo,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rd,
    input  logic        EX_BranchTaken,
    input  logic        EX_Jump,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        MduStart,
    output logic        MduBusy,
    output logic [15:0] StallCount
);
    logic load_use, mdu_haz, redirect, stall;
    assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                      ((ID_UsesRs && ID_Rs == EX_Rd) || (ID_UsesRt && ID_Rt == EX_Rd));
    assign redirect = EX_BranchTaken || EX_Jump;
    // The ID instruction is on the wrong path when redirecting, so a flush beats a stall.
    assign stall      = (load_use || mdu_haz) && !redirect;
    assign PCWrite    = !stall;
    assign IFIDWrite  = !stall;
    assign IFIDFlush  = redirect;
    assign IDEXBubble = redirect || stall;
`ifdef HAZARD_MDU_EN
    typedef enum logic {IDLE, RUN} state_t;
    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // A redirect never aborts RUN: the running op is older than the branch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        MduStart = ID_IsMdu && (state == IDLE) && !load_use && !redirect;
        if (state == IDLE) begin
            if (MduStart) begin
                state_nx = RUN;
                cnt_nx   = 4'(MDU_LATENCY - 1);
            end
        end else if (cnt != 4'd0) begin
            cnt_nx = cnt - 4'd1;
        end else begin
            state_nx = IDLE;
        end
    end
    assign MduBusy = (state == RUN);
    assign mdu_haz = MduBusy && (ID_IsMdu || ID_ReadsHiLo);
`else
    // Single-cycle multiplier in EX: MDU hints are irrelevant.
    logic unused_mdu;
    assign unused_mdu = ID_IsMdu ^ ID_ReadsHiLo;
    assign MduStart   = 1'b0;
    assign MduBusy    = 1'b0;
    assign mdu_haz    = 1'b0;
`endif
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            StallCount <= 16'd0;
        else if (stall && StallCount != 16'hFFFF)
            StallCount <= StallCount + 16'd1;
    end
endmodule
